// File: rtl/sdram_client_arbiter.sv
// sdram_client_arbiter: shares one SDRAM controller port between the processor and scanout (one read burst per request).
// Define ARB_PERF_COUNT_EN to add the grant counter and the worst-case yield-wait counter.
module sdram_client_arbiter #(
  parameter int BURST_LEN = 8,
  parameter int ADDR_W    = 22,
  parameter int DATA_W    = 32
) (
  input  logic              i_Clk,
  input  logic              i_Rst_n,
  input  logic [1:0]        i_Proc_Command,
  input  logic [ADDR_W-1:0] i_Proc_Address,
  input  logic [DATA_W-1:0] i_Proc_Data_Write,
  input  logic              i_Proc_Yield,
  output logic              o_Proc_Requested,
  output logic              o_Proc_Read_Valid,
  output logic              o_Proc_Write_Done,
  input  logic              i_Disp_Req,
  input  logic [ADDR_W-1:0] i_Disp_Address,
  output logic              o_Disp_Busy,
  output logic [DATA_W-1:0] o_Disp_Data,
  output logic              o_Disp_Valid,
  output logic              o_Disp_Done,
  output logic [1:0]        o_Command,
  output logic [ADDR_W-1:0] o_Data_Address,
  output logic [DATA_W-1:0] o_Data_Write,
  input  logic              i_Data_Read_Valid,
  input  logic              i_Data_Write_Done,
  input  logic [DATA_W-1:0] i_Data_Read
`ifdef ARB_PERF_COUNT_EN
  ,
  output logic [15:0]       o_Grant_Count,
  output logic [15:0]       o_Yield_Wait_Max
`endif
);
  localparam logic [1:0] CMD_IDLE = 2'd0;
  localparam logic [1:0] CMD_READ = 2'd1;
  localparam int CNT_W = $clog2(BURST_LEN) + 1;

  typedef enum logic [1:0] {OWN_PROC, WAIT_YIELD, OWN_DISP, RELEASE} state_t;

  state_t            state_q, state_d;
  logic              busy_q, busy_d, req_q, req_d, last;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    last    = cnt_q == CNT_W'(BURST_LEN - 1);
    if (i_Disp_Req && !busy_q && state_q != RELEASE) begin
      busy_d = 1'b1;
      addr_d = i_Disp_Address;
    end
    case (state_q)
      OWN_PROC:   state_d = busy_q ? WAIT_YIELD : OWN_PROC;
      WAIT_YIELD: state_d = i_Proc_Yield ? OWN_DISP : WAIT_YIELD;
      OWN_DISP: begin
        if (i_Data_Read_Valid) begin
          cnt_d = last ? '0 : cnt_q + CNT_W'(1);
          if (last) begin
            state_d = RELEASE;
            busy_d  = 1'b0;
          end
        end
      end
      default:    state_d = OWN_PROC;
    endcase
    // Requested stays high across the whole grant so the processor cannot leave idle mid-burst
    req_d = state_d == WAIT_YIELD || state_d == OWN_DISP;
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q <= OWN_PROC;
      busy_q  <= 1'b0;
      req_q   <= 1'b0;
      addr_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_Command         = state_q == OWN_DISP ? CMD_READ : state_q == RELEASE ? CMD_IDLE : i_Proc_Command;
  assign o_Data_Address    = state_q == OWN_DISP ? addr_q + ADDR_W'(cnt_q) : i_Proc_Address;
  assign o_Data_Write      = i_Proc_Data_Write;
  assign o_Proc_Read_Valid = i_Data_Read_Valid && state_q != OWN_DISP;
  assign o_Proc_Write_Done = i_Data_Write_Done && state_q != OWN_DISP;
  assign o_Disp_Valid      = i_Data_Read_Valid && state_q == OWN_DISP;
  assign o_Disp_Data       = i_Data_Read;
  assign o_Disp_Done       = state_q == RELEASE;
  assign o_Disp_Busy       = busy_q;
  assign o_Proc_Requested  = req_q;

`ifdef ARB_PERF_COUNT_EN
  logic [15:0] grant_q, grant_d, wait_q, wait_d, max_q, max_d;

  assign grant_d = state_q == RELEASE && grant_q != 16'hFFFF ? grant_q + 16'd1 : grant_q;
  assign wait_d  = state_q != WAIT_YIELD ? 16'd0 : wait_q == 16'hFFFF ? wait_q : wait_q + 16'd1;
  assign max_d   = state_q == WAIT_YIELD && wait_d > max_q ? wait_d : max_q;

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      grant_q <= '0;
      wait_q  <= '0;
      max_q   <= '0;
    end else begin
      grant_q <= grant_d;
      wait_q  <= wait_d;
      max_q   <= max_d;
    end
  end

  assign o_Grant_Count    = grant_q;
  assign o_Yield_Wait_Max = max_q;
`endif
endmodule
